fifo_write_arbiter: RTL and testbench

FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

---
 rtl/fifo_write_arbiter.sv | 80 ++++++++
 tb/tb_fifo_write_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin packet arbiter feeding several requesters into one FIFO write port
module fifo_write_arbiter #(
  parameter int WIDTH = 8,
  parameter int NUM_REQ = 4,
  parameter int MAX_BURST = 16,
  parameter int IDX_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]       req_last,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     fifo_full,
  output logic                     fifo_wr_en,
  output logic [WIDTH-1:0]         fifo_din,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     busy
);
  localparam int CW = $clog2(MAX_BURST + 1);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t               state_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic [IDX_WIDTH-1:0] gidx_q;
  logic [IDX_WIDTH-1:0] rr_ptr_q;
  logic [CW-1:0]        cnt_q;
  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [IDX_WIDTH-1:0] off;
  logic [IDX_WIDTH:0]   sum;
  logic [IDX_WIDTH-1:0] sel;
  logic [IDX_WIDTH-1:0] nxt;
  logic                 lock;
  logic                 xfer;
  logic                 done;
  // Rotate requests so rr_ptr sits at bit 0, take the lowest set bit, rotate the index back
  always_comb begin
    dbl = {req_valid, req_valid} >> rr_ptr_q;
    rot = dbl[NUM_REQ-1:0];
    off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) off = rot[k] ? IDX_WIDTH'(k) : off;
    sum = {1'b0, rr_ptr_q} + {1'b0, off};
    sel = (sum >= (IDX_WIDTH+1)'(NUM_REQ)) ? IDX_WIDTH'(sum - (IDX_WIDTH+1)'(NUM_REQ)) : IDX_WIDTH'(sum);
  end
  assign lock       = (state_q == LOCKED) && !rst;
  assign xfer       = lock && req_valid[gidx_q] && !fifo_full;
  assign done       = req_last[gidx_q] || (({1'b0, cnt_q} + 1'b1) == (CW+1)'(MAX_BURST));
  assign nxt        = (gidx_q == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
  assign req_ready  = (lock && !fifo_full) ? grant_q : '0;
  assign fifo_wr_en = xfer;
  assign fifo_din   = req_data[gidx_q*WIDTH +: WIDTH];
  assign grant      = grant_q;
  assign busy       = (state_q == LOCKED);
  // Grant on an idle cycle, count accepted beats, release on last beat or burst limit
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      gidx_q   <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (state_q == IDLE) begin
      if (|req_valid) begin
        state_q <= LOCKED;
        grant_q <= NUM_REQ'(1) << sel;
        gidx_q  <= sel;
        cnt_q   <= '0;
      end
    end else if (xfer) begin
      if (done) begin
        state_q  <= IDLE;
        grant_q  <= '0;
        cnt_q    <= '0;
        rr_ptr_q <= nxt;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: directed checks of arbitration order, bursts, backpressure and reset
module tb_fifo_write_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic [7:0]  dat [4];
  logic [31:0] req_data;
  logic        fifo_full;
  logic [3:0]  ready0, grant0, ready1, grant1;
  logic        wr0, busy0, wr1, busy1;
  logic [7:0]  din0, din1;
  int          checks = 0;
  int          failures = 0;

  assign req_data = {dat[3], dat[2], dat[1], dat[0]};

  always #5 clk = ~clk;

  fifo_write_arbiter #(.WIDTH(8), .NUM_REQ(4), .MAX_BURST(16)) u0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(ready0), .fifo_full(fifo_full), .fifo_wr_en(wr0), .fifo_din(din0),
    .grant(grant0), .busy(busy0));

  fifo_write_arbiter #(.WIDTH(8), .NUM_REQ(4), .MAX_BURST(4)) u1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(ready1), .fifo_full(fifo_full), .fifo_wr_en(wr1), .fifo_din(din1),
    .grant(grant1), .busy(busy1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lk(input string t, input logic [3:0] g, input logic [7:0] d, input logic w);
    chk({t, ".grant"}, grant0, g);
    chk({t, ".busy"}, busy0, 1);
    chk({t, ".wr_en"}, wr0, w);
    chk({t, ".ready"}, ready0, fifo_full ? 4'b0 : g);
    if (w) chk({t, ".din"}, din0, d);
  endtask

  task automatic id(input string t);
    chk({t, ".grant"}, grant0, 0);
    chk({t, ".busy"}, busy0, 0);
    chk({t, ".wr_en"}, wr0, 0);
    chk({t, ".ready"}, ready0, 0);
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    req_valid = '0;
    req_last = '0;
    fifo_full = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_last = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < 4; i++) dat[i] = '0;
    step();
    step();
    id("reset");
    chk("reset.u1_busy", busy1, 0);
    chk("reset.u1_grant", grant1, 0);

    rst = 1'b0;
    req_valid = 4'hF;
    req_last = 4'hF;
    for (int i = 0; i < 4; i++) dat[i] = 8'h10 + 8'(i);
    for (int n = 0; n < 5; n++) begin
      step();
      lk($sformatf("rr%0d", n), 4'b0001 << (n % 4), 8'h10 + 8'(n % 4), 1'b1);
      step();
      id($sformatf("rr_gap%0d", n));
    end

    rst_pulse();
    req_valid = 4'b0100;
    dat[2] = 8'hA0;
    dat[1] = 8'h55;
    step();
    req_valid = 4'b0110;
    for (int k = 0; k < 5; k++) begin
      dat[2] = 8'hA0 + 8'(k);
      req_last = (k == 4) ? 4'b0100 : 4'b0000;
      #1;
      lk($sformatf("pkt_beat%0d", k), 4'b0100, 8'hA0 + 8'(k), 1'b1);
      step();
    end
    req_valid = 4'b0111;
    req_last = 4'hF;
    dat[0] = 8'h30;
    #1;
    id("pkt_gap");
    step();
    lk("after_pkt", 4'b0001, 8'h30, 1'b1);
    step();
    id("after_pkt_gap");
    req_valid = 4'b0110;
    step();
    lk("rr_next", 4'b0010, 8'h55, 1'b1);

    rst_pulse();
    req_valid = 4'b0010;
    dat[1] = 8'hC0;
    step();
    #1;
    lk("full_c0", 4'b0010, 8'hC0, 1'b1);
    step();
    dat[1] = 8'hC1;
    #1;
    lk("full_c1", 4'b0010, 8'hC1, 1'b1);
    step();
    fifo_full = 1'b1;
    dat[1] = 8'hC2;
    for (int k = 0; k < 3; k++) begin
      #1;
      lk($sformatf("full_hold%0d", k), 4'b0010, 8'hC2, 1'b0);
      step();
    end
    fifo_full = 1'b0;
    #1;
    lk("full_c2", 4'b0010, 8'hC2, 1'b1);
    step();
    req_valid = 4'b0000;
    req_last = 4'b0010;
    #1;
    lk("novalid", 4'b0010, 8'hC2, 1'b0);
    chk("novalid.u1_busy", busy1, 1);
    step();
    req_valid = 4'b0010;
    req_last = 4'b0000;
    dat[1] = 8'hC3;
    #1;
    lk("full_c3", 4'b0010, 8'hC3, 1'b1);
    chk("full_c3.u1_wr", wr1, 1);
    chk("full_c3.u1_din", din1, 8'hC3);
    step();
    dat[1] = 8'hC4;
    req_last = 4'b0010;
    #1;
    chk("limit4.u1_busy", busy1, 0);
    lk("full_c4", 4'b0010, 8'hC4, 1'b1);
    step();
    id("full_rel");

    rst_pulse();
    req_valid = 4'b1000;
    dat[3] = 8'hD0;
    step();
    #1;
    lk("rst_d0", 4'b1000, 8'hD0, 1'b1);
    step();
    dat[3] = 8'hD1;
    rst = 1'b1;
    #1;
    chk("rst_mid.wr_en", wr0, 0);
    chk("rst_mid.ready", ready0, 0);
    step();
    id("rst_after");
    rst = 1'b0;
    req_valid = 4'hF;
    req_last = 4'hF;
    dat[0] = 8'h40;
    step();
    lk("rst_rr", 4'b0001, 8'h40, 1'b1);

    rst_pulse();
    req_valid = 4'b0011;
    dat[1] = 8'h66;
    step();
    for (int k = 0; k < 4; k++) begin
      dat[0] = 8'hE0 + 8'(k);
      #1;
      chk($sformatf("burst%0d.u1_grant", k), grant1, 4'b0001);
      chk($sformatf("burst%0d.u1_wr", k), wr1, 1);
      chk($sformatf("burst%0d.u1_din", k), din1, 8'hE0 + 8'(k));
      step();
    end
    dat[0] = 8'hE4;
    #1;
    chk("burst_rel.u1_busy", busy1, 0);
    chk("burst_rel.u1_ready", ready1, 0);
    lk("burst_u0_cont", 4'b0001, 8'hE4, 1'b1);
    step();
    chk("burst_next.u1_grant", grant1, 4'b0010);
    chk("burst_next.u1_wr", wr1, 1);
    chk("burst_next.u1_din", din1, 8'h66);

    rst_pulse();
    req_valid = 4'b0001;
    step();
    for (int k = 0; k < 4; k++) begin
      req_last = (k == 3) ? 4'b0001 : 4'b0000;
      #1;
      chk($sformatf("both%0d.u1_wr", k), wr1, 1);
      step();
    end
    req_last = 4'b0000;
    chk("both_rel.u1_busy", busy1, 0);
    chk("both_rel.u1_grant", grant1, 0);
    step();
    chk("both_regrant.u1_grant", grant1, 4'b0001);
    chk("both_regrant.u1_busy", busy1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
